mux_nto1_rr: RTL

Parametrised N-channel, WIDTH-bit registered channel selector with a valid/ready handshake on every input and on the output. It is the generalised successor of the plain two-input multiplexer. It adds channel count, a registered output stage, backpressure, and a second mode: round-robin arbitration alongside fixed selection. It sits between several producers (bus masters, peripheral data sources) and one consumer in the CPU datapath, and moves at most one word per cycle.

---
 rtl/mux_nto1_rr.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux_nto1_rr.sv
// N-channel registered selector with valid/ready on every port.
// Fixed-select or round-robin arbitration feeding a single output register.

module mux_nto1_rr_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            rst,
  input  logic            load_en,
  input  logic            grant,
  input  logic [SELW-1:0] chosen,
  output logic            in_ready
);
  assign in_ready = !rst && load_en && grant && (chosen == SELW'(IDX));
endmodule

module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  typedef struct packed {
    logic             vld;
    logic [SELW-1:0]  chan;
    logic [WIDTH-1:0] data;
  } out_t;

  logic [N-1:0][WIDTH-1:0] lane_data;
  out_t                    oreg;
  logic [SELW-1:0]         ptr;
  logic                    load_en;
  logic                    grant;
  logic [SELW-1:0]         chosen;
  logic [WIDTH-1:0]        cand_data;
  int                      idx;

  assign lane_data = in_data;
  assign load_en   = !oreg.vld || out_ready;

  // Round-robin scans ptr+1 .. ptr (mod N); ptr is always < N so one wrap suffices.
  always_comb begin
    grant  = 1'b0;
    chosen = '0;
    idx    = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant  = 1'b1;
          chosen = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!grant && in_valid[idx]) begin
          grant  = 1'b1;
          chosen = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N; i++)
      if (chosen == SELW'(i)) cand_data = lane_data[i];
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    mux_nto1_rr_lane #(.SELW(SELW), .IDX(g)) u_lane (
      .rst      (rst),
      .load_en  (load_en),
      .grant    (grant),
      .chosen   (chosen),
      .in_ready (in_ready[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oreg <= '0;
      ptr  <= SELW'(N-1);
    end else if (load_en) begin
      if (grant) begin
        oreg.vld  <= 1'b1;
        oreg.chan <= chosen;
        oreg.data <= cand_data;
        ptr       <= chosen;
      end else begin
        oreg.vld  <= 1'b0;
      end
    end
  end

  assign out_valid = oreg.vld;
  assign out_chan  = oreg.chan;
  assign out_data  = oreg.data;

endmodule
